packet_scheduler: RTL and testbench

PACKET_SCHEDULER -- requirements
Module: packet_scheduler

---
 rtl/hdmi_packet_pkg.sv | 15 +
 rtl/packet_scheduler.sv | 149 ++++++++++++++
 tb/tb_packet_scheduler.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/hdmi_packet_pkg.sv
// Shared HDMI data island definitions: packet header byte 0 codes and the
// scheduler state encoding used by the packet builders.
package hdmi_packet_pkg;

    localparam logic [7:0] HB0_NULL  = 8'h00;
    localparam logic [7:0] HB0_ACR   = 8'h01;
    localparam logic [7:0] HB0_AUDIO = 8'h02;
    localparam logic [7:0] HB0_AVI   = 8'h82;
    localparam logic [7:0] HB0_AIF   = 8'h84;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT  = 2'd1;
    localparam logic [1:0] ST_ISLAND = 2'd2;

endpackage

// File: rtl/packet_scheduler.sv
// Data island packet scheduler: picks one packet per island slot with fixed
// priority ACR > audio sample > AVI InfoFrame > audio InfoFrame > null.
module packet_scheduler
    import hdmi_packet_pkg::*;
#(
    parameter int INFOFRAME_EN = 1,
    parameter int ISLAND_LEN   = 32
) (
    input  logic       clk_pixel,
    input  logic       reset,
    input  logic       enable,
    input  logic       frame_start,
    input  logic       island_slot,
    input  logic       acr_tick,
    input  logic       audio_valid,
    output logic [7:0] packet_type,
    output logic       packet_strobe,
    output logic       audio_pop,
    output logic       busy,
    output logic       slot_err,
    output logic       if_overrun
);

    localparam int            CW    = (ISLAND_LEN > 1) ? $clog2(ISLAND_LEN) : 1;
    localparam logic [CW-1:0] LAST  = CW'(ISLAND_LEN - 1);
    localparam logic          IF_EN = (INFOFRAME_EN != 0);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    acr_cnt_q, acr_cnt_d;
    logic          avi_pend_q, avi_pend_d;
    logic          aif_pend_q, aif_pend_d;
    logic [7:0]    type_q, type_d;
    logic          strobe_q, strobe_d;
    logic          pop_q, pop_d;
    logic          err_q, err_d;
    logic          ovr_q, ovr_d;

    logic          last_island;
    logic          slot_ok;
    logic [7:0]    sel_type;
    logic          grant_acr, grant_aud, grant_avi, grant_aif;

    assign last_island = (state_q == ST_ISLAND) && (cnt_q == LAST);
    assign slot_ok     = island_slot && ((state_q == ST_IDLE) || last_island);

    always_comb begin
        sel_type = HB0_NULL;
        if (!enable)
            sel_type = HB0_NULL;
        else if (acr_cnt_q != 2'd0)
            sel_type = HB0_ACR;
        else if (audio_valid)
            sel_type = HB0_AUDIO;
        else if (IF_EN && avi_pend_q)
            sel_type = HB0_AVI;
        else if (IF_EN && aif_pend_q)
            sel_type = HB0_AIF;
    end

    assign grant_acr = slot_ok && (sel_type == HB0_ACR);
    assign grant_aud = slot_ok && (sel_type == HB0_AUDIO);
    assign grant_avi = slot_ok && (sel_type == HB0_AVI);
    assign grant_aif = slot_ok && (sel_type == HB0_AIF);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (slot_ok) state_d = ST_GRANT;
            end
            ST_GRANT: begin
                state_d = ST_ISLAND;
                cnt_d   = '0;
            end
            ST_ISLAND: begin
                if (last_island)
                    state_d = slot_ok ? ST_GRANT : ST_IDLE;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        acr_cnt_d = acr_cnt_q;
        if (acr_tick && !grant_acr) begin
            if (acr_cnt_q != 2'd3) acr_cnt_d = acr_cnt_q + 2'd1;
        end else if (!acr_tick && grant_acr) begin
            acr_cnt_d = acr_cnt_q - 2'd1;
        end
    end

    // A new frame re-arms the InfoFrames even if one is granted this cycle.
    always_comb begin
        avi_pend_d = avi_pend_q;
        aif_pend_d = aif_pend_q;
        if (grant_avi) avi_pend_d = 1'b0;
        if (grant_aif) aif_pend_d = 1'b0;
        if (frame_start && IF_EN) begin
            avi_pend_d = 1'b1;
            aif_pend_d = 1'b1;
        end
    end

    always_comb begin
        type_d   = slot_ok ? sel_type : type_q;
        strobe_d = slot_ok;
        pop_d    = grant_aud;
        err_d    = island_slot && !slot_ok;
        ovr_d    = frame_start && (avi_pend_q || aif_pend_q);
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            acr_cnt_q  <= '0;
            avi_pend_q <= 1'b0;
            aif_pend_q <= 1'b0;
            type_q     <= HB0_NULL;
            strobe_q   <= 1'b0;
            pop_q      <= 1'b0;
            err_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acr_cnt_q  <= acr_cnt_d;
            avi_pend_q <= avi_pend_d;
            aif_pend_q <= aif_pend_d;
            type_q     <= type_d;
            strobe_q   <= strobe_d;
            pop_q      <= pop_d;
            err_q      <= err_d;
            ovr_q      <= ovr_d;
        end
    end

    assign packet_type   = type_q;
    assign packet_strobe = strobe_q;
    assign audio_pop     = pop_q;
    assign busy          = (state_q != ST_IDLE);
    assign slot_err      = err_q;
    assign if_overrun    = ovr_q;

endmodule

// File: tb/tb_packet_scheduler.sv
// Directed bench for packet_scheduler: a table of single-cycle vectors
// separated by idle gaps, plus hand sequences for slot timing and reset.
module tb_packet_scheduler;
    import hdmi_packet_pkg::*;

    localparam int LEN = 32;

    logic       clk_pixel   = 1'b0;
    logic       reset       = 1'b1;
    logic       enable      = 1'b1;
    logic       frame_start = 1'b0;
    logic       island_slot = 1'b0;
    logic       acr_tick    = 1'b0;
    logic       audio_valid = 1'b0;
    logic [7:0] packet_type;
    logic       packet_strobe, audio_pop, busy, slot_err, if_overrun;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_pixel = ~clk_pixel;

    packet_scheduler #(.INFOFRAME_EN(1), .ISLAND_LEN(LEN)) dut (
        .clk_pixel    (clk_pixel),
        .reset        (reset),
        .enable       (enable),
        .frame_start  (frame_start),
        .island_slot  (island_slot),
        .acr_tick     (acr_tick),
        .audio_valid  (audio_valid),
        .packet_type  (packet_type),
        .packet_strobe(packet_strobe),
        .audio_pop    (audio_pop),
        .busy         (busy),
        .slot_err     (slot_err),
        .if_overrun   (if_overrun)
    );

    typedef struct {
        int         gap;
        logic       en, av, fs, acr, slot;
        logic [7:0] typ;
        logic       strb, pop, bsy, err, ovr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int gap, logic en, logic av, logic fs, logic acr, logic slot,
                                logic [7:0] typ, logic strb, logic pop, logic bsy,
                                logic err, logic ovr);
        vec_t v;
        v.gap = gap; v.en = en; v.av = av; v.fs = fs; v.acr = acr; v.slot = slot;
        v.typ = typ; v.strb = strb; v.pop = pop; v.bsy = bsy; v.err = err; v.ovr = ovr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [7:0] typ, input logic strb,
                             input logic pop, input logic bsy, input logic err, input logic ovr);
        chk({tag, " type"},   packet_type,   typ);
        chk({tag, " strobe"}, packet_strobe, strb);
        chk({tag, " pop"},    audio_pop,     pop);
        chk({tag, " busy"},   busy,          bsy);
        chk({tag, " err"},    slot_err,      err);
        chk({tag, " ovr"},    if_overrun,    ovr);
    endtask

    task automatic apply(input vec_t v, input int idx);
        enable      = v.en;
        audio_valid = v.av;
        frame_start = 1'b0;
        acr_tick    = 1'b0;
        island_slot = 1'b0;
        repeat (v.gap) clk1();
        frame_start = v.fs;
        acr_tick    = v.acr;
        island_slot = v.slot;
        clk1();
        frame_start = 1'b0;
        acr_tick    = 1'b0;
        island_slot = 1'b0;
        check_all($sformatf("v%0d", idx), v.typ, v.strb, v.pop, v.bsy, v.err, v.ovr);
    endtask

    initial begin
        // gap en av fs acr slot | type strobe pop busy err ovr
        vecs.push_back(mk( 2, 1, 1, 1, 1, 0, HB0_NULL,  0, 0, 0, 0, 0));
        vecs.push_back(mk( 0, 1, 1, 0, 0, 1, HB0_ACR,   1, 0, 1, 0, 0));
        vecs.push_back(mk(39, 1, 1, 0, 0, 1, HB0_AUDIO, 1, 1, 1, 0, 0));
        vecs.push_back(mk(39, 1, 1, 0, 0, 1, HB0_AUDIO, 1, 1, 1, 0, 0));
        vecs.push_back(mk(39, 1, 1, 0, 0, 1, HB0_AUDIO, 1, 1, 1, 0, 0));
        vecs.push_back(mk(39, 1, 0, 0, 0, 1, HB0_AVI,   1, 0, 1, 0, 0));
        vecs.push_back(mk(39, 1, 0, 0, 0, 1, HB0_AIF,   1, 0, 1, 0, 0));
        vecs.push_back(mk( 5, 1, 0, 0, 0, 0, HB0_AIF,   0, 0, 1, 0, 0));
        vecs.push_back(mk(39, 1, 0, 0, 0, 1, HB0_NULL,  1, 0, 1, 0, 0));
        // frame overrun, then frame_start coincident with the AVI grant
        vecs.push_back(mk(40, 1, 0, 1, 0, 0, HB0_NULL,  0, 0, 0, 0, 0));
        vecs.push_back(mk( 3, 1, 0, 1, 0, 0, HB0_NULL,  0, 0, 0, 0, 1));
        vecs.push_back(mk( 0, 1, 0, 1, 0, 1, HB0_AVI,   1, 0, 1, 0, 1));
        vecs.push_back(mk(39, 1, 0, 0, 0, 1, HB0_AVI,   1, 0, 1, 0, 0));
        vecs.push_back(mk(39, 1, 0, 0, 0, 1, HB0_AIF,   1, 0, 1, 0, 0));
        vecs.push_back(mk(39, 1, 0, 0, 0, 1, HB0_NULL,  1, 0, 1, 0, 0));
        // four ticks saturate at 3; tick + ACR grant keeps 3
        vecs.push_back(mk(39, 1, 0, 0, 1, 0, HB0_NULL,  0, 0, 0, 0, 0));
        vecs.push_back(mk( 0, 1, 0, 0, 1, 0, HB0_NULL,  0, 0, 0, 0, 0));
        vecs.push_back(mk( 0, 1, 0, 0, 1, 0, HB0_NULL,  0, 0, 0, 0, 0));
        vecs.push_back(mk( 0, 1, 0, 0, 1, 0, HB0_NULL,  0, 0, 0, 0, 0));
        vecs.push_back(mk( 0, 1, 0, 0, 1, 1, HB0_ACR,   1, 0, 1, 0, 0));
        vecs.push_back(mk(39, 1, 0, 0, 0, 1, HB0_ACR,   1, 0, 1, 0, 0));
        vecs.push_back(mk(39, 1, 0, 0, 0, 1, HB0_ACR,   1, 0, 1, 0, 0));
        vecs.push_back(mk(39, 1, 0, 0, 0, 1, HB0_ACR,   1, 0, 1, 0, 0));
        vecs.push_back(mk(39, 1, 0, 0, 0, 1, HB0_NULL,  1, 0, 1, 0, 0));
        // DVI mode grants null and keeps the ACR count
        vecs.push_back(mk(39, 1, 0, 0, 1, 0, HB0_NULL,  0, 0, 0, 0, 0));
        vecs.push_back(mk( 0, 0, 1, 0, 0, 1, HB0_NULL,  1, 0, 1, 0, 0));
        vecs.push_back(mk(39, 1, 1, 0, 0, 1, HB0_ACR,   1, 0, 1, 0, 0));
        vecs.push_back(mk(39, 1, 0, 0, 0, 1, HB0_NULL,  1, 0, 1, 0, 0));

        reset = 1'b1;
        repeat (2) clk1();
        check_all("reset", HB0_NULL, 0, 0, 0, 0, 0);
        reset = 1'b0;
        clk1();

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Slot during island is rejected; slot in the final island cycle is accepted.
        enable = 1'b1;
        repeat (40) clk1();
        audio_valid = 1'b1;
        island_slot = 1'b1;
        clk1();
        island_slot = 1'b0;
        audio_valid = 1'b0;
        check_all("grant0", HB0_AUDIO, 1, 1, 1, 0, 0);
        repeat (5) clk1();
        island_slot = 1'b1;
        clk1();
        island_slot = 1'b0;
        check_all("slot_g5", HB0_AUDIO, 0, 0, 1, 1, 0);
        clk1();
        chk("slot_err_single", slot_err, 1'b0);
        repeat (LEN - 7) clk1();
        island_slot = 1'b1;
        clk1();
        island_slot = 1'b0;
        check_all("slot_glen", HB0_NULL, 1, 0, 1, 0, 0);

        // Reset in the middle of an island.
        repeat (40) clk1();
        acr_tick    = 1'b1;
        frame_start = 1'b1;
        clk1();
        frame_start = 1'b0;
        clk1();
        acr_tick    = 1'b0;
        island_slot = 1'b1;
        clk1();
        island_slot = 1'b0;
        check_all("pre_reset", HB0_ACR, 1, 0, 1, 0, 0);
        repeat (3) clk1();
        #3 reset = 1'b1;
        #1;
        check_all("mid_reset", HB0_NULL, 0, 0, 0, 0, 0);
        clk1();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            clk1();
            chk($sformatf("post_reset%0d strobe", i), packet_strobe, 1'b0);
            chk($sformatf("post_reset%0d busy", i), busy, 1'b0);
        end
        island_slot = 1'b1;
        clk1();
        island_slot = 1'b0;
        check_all("after_reset", HB0_NULL, 1, 0, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
